// File: rtl/demux_1to2_stream_nbit_pkg.sv
// Shared definitions for the 1-to-2 stream demultiplexer.
// Lane identifiers, the lane occupancy type and its update rule.
package demux_1to2_stream_nbit_pkg;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef logic [1:0] lane_cnt_t;

  localparam lane_cnt_t LANE_EMPTY = 2'd0;
  localparam lane_cnt_t LANE_ONE   = 2'd1;
  localparam lane_cnt_t LANE_FULL  = 2'd2;

  // A simultaneous push and pop leaves the occupancy unchanged.
  function automatic lane_cnt_t lane_cnt_next(lane_cnt_t cnt, logic push, logic pop);
    lane_cnt_t nxt;
    unique case ({push, pop})
      2'b10:   nxt = lane_cnt_t'(cnt + 2'd1);
      2'b01:   nxt = lane_cnt_t'(cnt - 2'd1);
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/demux_1to2_stream_nbit_if.sv
// Handshake bundle for the demultiplexer: one input stream, two output lanes
// and the per-lane delivered-beat counters.
interface demux_1to2_stream_nbit_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);

  logic             i_valid;
  logic             o_ready;
  logic [N-1:0]     i_data;
  logic             i_sel;
  logic             o_valid0;
  logic             i_ready0;
  logic [N-1:0]     o_data0;
  logic             o_valid1;
  logic             i_ready1;
  logic [N-1:0]     o_data1;
  logic [CNT_W-1:0] o_cnt0;
  logic [CNT_W-1:0] o_cnt1;

  modport master (
    output i_valid, i_data, i_sel, i_ready0, i_ready1,
    input  o_ready, o_valid0, o_data0, o_valid1, o_data1, o_cnt0, o_cnt1
  );

  modport slave (
    input  i_valid, i_data, i_sel, i_ready0, i_ready1,
    output o_ready, o_valid0, o_data0, o_valid1, o_data1, o_cnt0, o_cnt1
  );

endinterface

// File: rtl/demux_1to2_stream_nbit_fifo2.sv
// Two-entry lane buffer. The head register drives the lane output directly,
// so output data is registered and held while the consumer stalls.
module stream_fifo2_nbit
  import demux_1to2_stream_nbit_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [N-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [N-1:0] head_o,
  output logic         full_o,
  output lane_cnt_t    cnt_o
);

  lane_cnt_t    cnt_q, cnt_d;
  logic         full_q;
  logic [N-1:0] head_q, head_d;
  logic [N-1:0] tail_q, tail_d;
  logic         push, pop;

  assign push = push_i & ~full_q;
  assign pop  = pop_i & (cnt_q != LANE_EMPTY);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = lane_cnt_next(cnt_q, push, pop);
    unique case (cnt_q)
      LANE_EMPTY: if (push) head_d = data_i;
      LANE_ONE: begin
        // With push and pop together the incoming beat replaces the head.
        if (push && pop) head_d = data_i;
        else if (push)   tail_d = data_i;
      end
      LANE_FULL: if (pop) head_d = tail_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= LANE_EMPTY;
      full_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == LANE_FULL);
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign valid_o = (cnt_q != LANE_EMPTY);
  assign head_o  = head_q;
  assign full_o  = full_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux_1to2_stream_nbit_mux.sv
// Plain 2-to-1 multiplexer, used for the input ready select.
module mux_2to1_nbit #(
  parameter int N = 1
) (
  input  logic         sel_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/demux_1to2_stream_nbit.sv
// Registered 1-to-2 stream demultiplexer with a two-entry buffer per lane
// and a wrapping delivered-beat counter per lane.
module demux_1to2_stream_nbit
  import demux_1to2_stream_nbit_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  demux_1to2_stream_nbit_if.slave bus
);

  logic             full0, full1;
  logic             ready;
  logic             push0, push1;
  logic             pop0, pop1;
  logic             valid0, valid1;
  logic [N-1:0]     head0, head1;
  lane_cnt_t        lane_cnt0, lane_cnt1;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Ready only looks at registered full flags, never at the consumer readies.
  mux_2to1_nbit #(.N(1)) u_ready_mux (
    .sel_i (bus.i_sel),
    .a_i   (~full0),
    .b_i   (~full1),
    .y_o   (ready)
  );

  assign push0 = bus.i_valid & ready & (bus.i_sel == LANE0);
  assign push1 = bus.i_valid & ready & (bus.i_sel == LANE1);
  assign pop0  = valid0 & bus.i_ready0;
  assign pop1  = valid1 & bus.i_ready1;

  stream_fifo2_nbit #(.N(N)) u_lane0 (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push_i  (push0),
    .data_i  (bus.i_data),
    .pop_i   (pop0),
    .valid_o (valid0),
    .head_o  (head0),
    .full_o  (full0),
    .cnt_o   (lane_cnt0)
  );

  stream_fifo2_nbit #(.N(N)) u_lane1 (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .push_i  (push1),
    .data_i  (bus.i_data),
    .pop_i   (pop1),
    .valid_o (valid1),
    .head_o  (head1),
    .full_o  (full1),
    .cnt_o   (lane_cnt1)
  );

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop0) cnt0_d = cnt0_q + 1'b1;
    if (pop1) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.o_ready  = ready;
  assign bus.o_valid0 = valid0;
  assign bus.o_data0  = head0;
  assign bus.o_valid1 = valid1;
  assign bus.o_data1  = head1;
  assign bus.o_cnt0   = cnt0_q;
  assign bus.o_cnt1   = cnt1_q;

  a_sel_known: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    bus.i_valid |-> !$isunknown(bus.i_sel));

endmodule
